// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin arbiter sharing one draw/compute datapath between NUM_REQ sequencers
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif
module dp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int INSTR_W = `INSTRUCTION_WIDTH,
  parameter int RES_W   = `RESULT_WIDTH,
  localparam int GNT_W  = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_start,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instruction,
  output logic [NUM_REQ-1:0]         req_finished,
  output logic [RES_W-1:0]           req_result,
  output logic                       start_dp,
  output logic [INSTR_W-1:0]         instruction_dp,
  input  logic                       finished_dp,
  input  logic [RES_W-1:0]           result_dp,
  output logic                       busy,
  output logic [GNT_W-1:0]           grant_id
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2, WAIT = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] fin_q, fin_d, pend_q, pend_d, cap, done_oh;
  logic [INSTR_W-1:0] ibuf_q [NUM_REQ];
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [GNT_W-1:0]   gnt_q, gnt_d, sel, idx;
  logic               start_q, start_d, any, done, grant;
  // Scan downward so the nearest pending index after the last grant wins.
  always_comb begin
    sel = gnt_q;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GNT_W'((int'(gnt_q) + k) % NUM_REQ);
      if (pend_q[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    done    = state_q == WAIT && finished_dp;
    done_oh = done ? NUM_REQ'(1) << gnt_q : '0;
    grant   = state_q == IDLE && any;
    cap     = req_start & fin_q;
    fin_d   = (fin_q & ~cap) | done_oh;
    pend_d  = (pend_q | cap) & ~done_oh;
    state_d = state_q == IDLE ? (any ? ISSUE : IDLE) :
              state_q == WAIT ? (finished_dp ? IDLE : WAIT) : state_q + 2'd1;
    start_d = grant || state_q == ISSUE;
    instr_d = grant ? ibuf_q[sel] : instr_q;
    gnt_d   = grant ? sel : gnt_q;
    res_d   = done ? result_dp : res_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      fin_q   <= '1;
      pend_q  <= '0;
      start_q <= 1'b0;
      instr_q <= '0;
      res_q   <= '0;
      gnt_q   <= GNT_W'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) ibuf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      instr_q <= instr_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      for (int i = 0; i < NUM_REQ; i++)
        if (cap[i]) ibuf_q[i] <= req_instruction[i*INSTR_W +: INSTR_W];
    end
  end
  assign req_finished   = fin_q;
  assign req_result     = res_q;
  assign start_dp       = start_q;
  assign instruction_dp = instr_q;
  assign busy           = state_q != IDLE;
  assign grant_id       = gnt_q;
endmodule
